// File: rtl/c_region_fifo_ctrl.sv
// c_region_fifo_ctrl: pointer/occupancy control for one VC region [min_addr, max_addr] of a shared buffer; optional sticky errors under C_REGION_FIFO_ERR_CHECK_EN.
// Latency: write/read address valid in the same cycle as the accepted op; count/empty/full update one edge later.
// Backpressure: push_ok drops when full unless a pop frees the slot; pop_ok drops when empty; flush blocks both.
module c_region_fifo_ctrl #(
  parameter int addr_width = 4,
  parameter int min_addr   = 4,
  parameter int max_addr   = 7,
  localparam int depth     = max_addr - min_addr + 1,
  localparam int cnt_width = $clog2(depth + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  output logic [addr_width-1:0] write_addr,
  output logic [addr_width-1:0] read_addr,
  output logic                  push_ok,
  output logic                  pop_ok,
  output logic [cnt_width-1:0]  count,
  output logic                  empty,
  output logic                  full,
  output logic [1:0]            errors
);

  localparam logic [addr_width-1:0] min_a   = addr_width'(min_addr);
  localparam logic [addr_width-1:0] max_a   = addr_width'(max_addr);
  localparam logic [cnt_width-1:0]  depth_c = cnt_width'(depth);

  logic [addr_width-1:0] wr_ptr_q, rd_ptr_q, wr_ptr_nxt, rd_ptr_nxt;
  logic [cnt_width-1:0]  count_q, count_nxt;
  logic                  empty_q, full_q;

  // Pointers walk downward and wrap from min_addr back to max_addr.
  function automatic logic [addr_width-1:0] decr(input logic [addr_width-1:0] x);
    return (x == min_a) ? max_a : x - addr_width'(1);
  endfunction

  // A pop may free the slot a same-cycle push needs, so push acceptance looks at pop_ok.
  assign pop_ok  = pop & ~flush & ~empty_q;
  assign push_ok = push & ~flush & (~full_q | pop_ok);

  // Next pointers and occupancy; flush returns the region to its reset state.
  always_comb begin
    wr_ptr_nxt = wr_ptr_q;
    rd_ptr_nxt = rd_ptr_q;
    count_nxt  = count_q;
    if (flush) begin
      wr_ptr_nxt = max_a;
      rd_ptr_nxt = max_a;
      count_nxt  = '0;
    end else begin
      if (push_ok) wr_ptr_nxt = decr(wr_ptr_q);
      if (pop_ok)  rd_ptr_nxt = decr(rd_ptr_q);
      case ({push_ok, pop_ok})
        2'b10:   count_nxt = count_q + cnt_width'(1);
        2'b01:   count_nxt = count_q - cnt_width'(1);
        default: count_nxt = count_q;
      endcase
    end
  end

  // State register; empty/full are registered so outputs have no input-to-output path.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= max_a;
      rd_ptr_q <= max_a;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_nxt;
      rd_ptr_q <= rd_ptr_nxt;
      count_q  <= count_nxt;
      empty_q  <= (count_nxt == '0);
      full_q   <= (count_nxt == depth_c);
    end
  end

  assign write_addr = wr_ptr_q;
  assign read_addr  = rd_ptr_q;
  assign count      = count_q;
  assign empty      = empty_q;
  assign full       = full_q;

`ifdef C_REGION_FIFO_ERR_CHECK_EN
  logic [1:0] err_q;

  // Sticky {overflow, underflow}: only reset clears them, flush does not.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 2'b00;
    end else begin
      if (push & full_q & ~pop & ~flush) err_q[1] <= 1'b1;
      if (pop & empty_q & ~flush)        err_q[0] <= 1'b1;
    end
  end

  assign errors = err_q;
`else
  assign errors = 2'b00;
`endif

endmodule

// File: tb/tb_c_region_fifo_ctrl.sv
module tb_c_region_fifo_ctrl;

  localparam int AW    = 4;
  localparam int MINA  = 4;
  localparam int MAXA  = 7;
  localparam int DEPTH = MAXA - MINA + 1;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          push = 1'b0, pop = 1'b0, flush = 1'b0;
  logic [AW-1:0] write_addr, read_addr;
  logic          push_ok, pop_ok, empty, full;
  logic [CW-1:0] count;
  logic [1:0]    errors;

  c_region_fifo_ctrl #(.addr_width(AW), .min_addr(MINA), .max_addr(MAXA)) dut (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .flush(flush),
    .write_addr(write_addr), .read_addr(read_addr), .push_ok(push_ok),
    .pop_ok(pop_ok), .count(count), .empty(empty), .full(full), .errors(errors)
  );

  always #5 clk = ~clk;

  typedef struct {
    int push_ok, pop_ok, waddr, raddr, cnt, empty, full, err;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0, n_bad = 0;
  int   n_issued = 0, n_checked = 0;

  // Reference model: occupancy plus totals of accepted pushes/pops since last clear.
  int   m_n = 0, m_wtot = 0, m_rtot = 0, m_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_n = 0; m_wtot = 0; m_rtot = 0;
  endtask

  // One clock cycle of stimulus: drive, queue the expected response, advance model.
  task automatic cycle(input bit p, input bit r, input bit f);
    exp_t e;
    int   pk, rk;
    @(negedge clk);
    push = p; pop = r; flush = f;
    #1;
    rk = (r && !f && m_n > 0) ? 1 : 0;
    pk = (p && !f && (m_n < DEPTH || rk == 1)) ? 1 : 0;
    e.push_ok = pk;
    e.pop_ok  = rk;
    e.waddr   = MAXA - (m_wtot % DEPTH);
    e.raddr   = MAXA - (m_rtot % DEPTH);
    e.cnt     = m_n;
    e.empty   = (m_n == 0) ? 1 : 0;
    e.full    = (m_n == DEPTH) ? 1 : 0;
    e.err     = m_err;
    q.push_back(e);
    n_issued++;
`ifdef C_REGION_FIFO_ERR_CHECK_EN
    if (p && m_n == DEPTH && !r && !f) m_err = m_err | 2;
    if (r && m_n == 0 && !f)           m_err = m_err | 1;
`endif
    if (f) model_clear();
    else begin
      m_n    = m_n + pk - rk;
      m_wtot = m_wtot + pk;
      m_rtot = m_rtot + rk;
    end
  endtask

  // Asynchronous reset asserted between edges; outputs must clear before the next edge.
  task automatic async_reset();
    @(negedge clk);
    push = 1'b0; pop = 1'b0; flush = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("arst_write_addr", int'(write_addr), MAXA);
    check("arst_read_addr", int'(read_addr), MAXA);
    check("arst_count", int'(count), 0);
    check("arst_empty", int'(empty), 1);
    check("arst_full", int'(full), 0);
    check("arst_errors", int'(errors), 0);
    model_clear();
    m_err = 0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Monitor: compares DUT outputs against each queued expectation, away from the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_checked++;
        check("push_ok", int'(push_ok), e.push_ok);
        check("pop_ok", int'(pop_ok), e.pop_ok);
        check("write_addr", int'(write_addr), e.waddr);
        check("read_addr", int'(read_addr), e.raddr);
        check("count", int'(count), e.cnt);
        check("empty", int'(empty), e.empty);
        check("full", int'(full), e.full);
        check("errors", int'(errors), e.err);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int p_pct, r_pct;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    // Reset state, then fill to full (addresses 7,6,5,4 then wrap to 7).
    cycle(0, 0, 0);
    repeat (4) cycle(1, 0, 0);
    // Push while full, then hold idle to see the sticky flag persist.
    cycle(1, 0, 0);
    cycle(0, 0, 0);
    // Full with simultaneous push+pop: count stays at depth, both pointers move.
    repeat (3) cycle(1, 1, 0);
    // Drain to empty, then push+pop while empty: only the push lands.
    repeat (4) cycle(0, 1, 0);
    cycle(1, 1, 0);
    cycle(0, 0, 0);
    // Occupancy 2 then asynchronous reset mid-cycle.
    cycle(1, 0, 0);
    cycle(0, 0, 0);
    async_reset();
    cycle(0, 0, 0);
    // Occupancy 3 then flush; flush with push/pop pending must accept neither.
    repeat (3) cycle(1, 0, 0);
    cycle(1, 1, 1);
    cycle(0, 0, 0);
    // Randomized traffic with shifting push/pop bias, rare flush and reset.
    for (int i = 0; i < 3000; i++) begin
      p_pct = ((i / 200) % 2 == 0) ? 70 : 30;
      r_pct = 100 - p_pct;
      if ($urandom_range(0, 499) == 0) async_reset();
      else cycle($urandom_range(0, 99) < p_pct, $urandom_range(0, 99) < r_pct,
                 $urandom_range(0, 49) == 0);
    end
    cycle(0, 0, 0);
    repeat (3) @(negedge clk);
    #4;
    check("scoreboard_drained", n_checked, n_issued);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
